// File: rtl/speed_sched_pkg.sv
// Shared types and period arithmetic for the game-speed tick scheduler.
// Period and reload values are computed wide so a large level step can never underflow.
package speed_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sched_state_e;

    typedef logic [63:0] wide_t;

    // P(L) = max(minPer, basePer - L*stepPer), evaluated without a subtraction that could wrap.
    function automatic wide_t period_of(input wide_t level, input wide_t basePer,
                                        input wide_t stepPer, input wide_t minPer);
        wide_t cut;
        cut = level * stepPer;
        if (cut + minPer >= basePer) begin
            return minPer;
        end
        return basePer - cut;
    endfunction

    // R(L) = 2**W - P(L); callers keep the low W bits.
    function automatic wide_t reload_of(input wide_t level, input int dataWidth, input wide_t basePer,
                                        input wide_t stepPer, input wide_t minPer);
        return (wide_t'(1) << dataWidth) - period_of(level, basePer, stepPer, minPer);
    endfunction

endpackage

// File: rtl/speed_tick_scheduler_if.sv
// Control and status bundle between the game controller and the tick scheduler.
// The controller side drives the one-cycle command pulses; the scheduler returns tick and status.
interface speed_tick_scheduler_if #(
    parameter int LEVELBITS = 3
);
    logic                 CC_SPEEDSCHED_start_In;
    logic                 CC_SPEEDSCHED_pause_In;
    logic                 CC_SPEEDSCHED_stop_In;
    logic                 CC_SPEEDSCHED_lvlup_In;
    logic                 CC_SPEEDSCHED_tick_Out;
    logic [LEVELBITS-1:0] CC_SPEEDSCHED_level_OutBUS;
    logic                 CC_SPEEDSCHED_running_Out;
    logic                 CC_SPEEDSCHED_paused_Out;

    modport master (
        output CC_SPEEDSCHED_start_In,
        output CC_SPEEDSCHED_pause_In,
        output CC_SPEEDSCHED_stop_In,
        output CC_SPEEDSCHED_lvlup_In,
        input  CC_SPEEDSCHED_tick_Out,
        input  CC_SPEEDSCHED_level_OutBUS,
        input  CC_SPEEDSCHED_running_Out,
        input  CC_SPEEDSCHED_paused_Out
    );

    modport slave (
        input  CC_SPEEDSCHED_start_In,
        input  CC_SPEEDSCHED_pause_In,
        input  CC_SPEEDSCHED_stop_In,
        input  CC_SPEEDSCHED_lvlup_In,
        output CC_SPEEDSCHED_tick_Out,
        output CC_SPEEDSCHED_level_OutBUS,
        output CC_SPEEDSCHED_running_Out,
        output CC_SPEEDSCHED_paused_Out
    );
endinterface

// File: rtl/speed_period_lut.sv
// Combinational level -> prescaler reload value R(level) = 2**W - P(level).
// Only a handful of levels exist, so this folds into a small constant mux.
module speed_period_lut
    import speed_sched_pkg::*;
#(
    parameter int SPEEDSCHED_DATAWIDTH = 23,
    parameter int SPEEDSCHED_LEVELBITS = 3,
    parameter int SPEEDSCHED_BASE_PER  = 5000000,
    parameter int SPEEDSCHED_STEP_PER  = 500000,
    parameter int SPEEDSCHED_MIN_PER   = 1000000
) (
    input  logic [SPEEDSCHED_LEVELBITS-1:0] level,
    output logic [SPEEDSCHED_DATAWIDTH-1:0] reload
);
    assign reload = SPEEDSCHED_DATAWIDTH'(reload_of(wide_t'(level), SPEEDSCHED_DATAWIDTH,
                                                    wide_t'(SPEEDSCHED_BASE_PER),
                                                    wide_t'(SPEEDSCHED_STEP_PER),
                                                    wide_t'(SPEEDSCHED_MIN_PER)));
endmodule

// File: rtl/speed_tick_scheduler.sv
// Game-speed controller: run/pause/stop sequencing, prescaler with all-ones terminal detect,
// one-cycle tick pulses and a speed level raised on request or every TICKS_LVL ticks.
module speed_tick_scheduler
    import speed_sched_pkg::*;
#(
    parameter int SPEEDSCHED_DATAWIDTH = 23,
    parameter int SPEEDSCHED_LEVELBITS = 3,
    parameter int SPEEDSCHED_BASE_PER  = 5000000,
    parameter int SPEEDSCHED_STEP_PER  = 500000,
    parameter int SPEEDSCHED_MIN_PER   = 1000000,
    parameter int SPEEDSCHED_TICKS_LVL = 64
) (
    input  logic                         CC_SPEEDSCHED_CLOCK_50,
    input  logic                         CC_SPEEDSCHED_RESET_InLow,
    speed_tick_scheduler_if.slave        bus
);
    localparam int W   = SPEEDSCHED_DATAWIDTH;
    localparam int LB  = SPEEDSCHED_LEVELBITS;
    localparam int TCW = (SPEEDSCHED_TICKS_LVL > 2) ? $clog2(SPEEDSCHED_TICKS_LVL) : 1;

    localparam logic [W-1:0]   RELOAD0    = W'(reload_of(wide_t'(0), W, wide_t'(SPEEDSCHED_BASE_PER),
                                                         wide_t'(SPEEDSCHED_STEP_PER),
                                                         wide_t'(SPEEDSCHED_MIN_PER)));
    localparam logic [W-1:0]   COUNT_TERM = '1;
    localparam logic [LB-1:0]  LEVEL_MAX  = '1;
    localparam logic [TCW-1:0] TICKS_LAST = TCW'((SPEEDSCHED_TICKS_LVL > 0) ? SPEEDSCHED_TICKS_LVL - 1 : 0);
    localparam bit             AUTO_EN    = (SPEEDSCHED_TICKS_LVL != 0);

    sched_state_e   state, stateNext;
    logic [W-1:0]   counter, counterNext, reloadNext;
    logic [LB-1:0]  level, levelNext, levelAfter;
    logic [TCW-1:0] tickCnt, tickCntNext;
    logic           tick, tickNext;
    logic           terminal, autoAdvance, advance;

    assign terminal    = (state == RUN) && (counter == COUNT_TERM);
    assign autoAdvance = AUTO_EN && terminal && (tickCnt == TICKS_LAST);
    assign advance     = (state == RUN) && (bus.CC_SPEEDSCHED_lvlup_In || autoAdvance);
    assign levelAfter  = (advance && (level != LEVEL_MAX)) ? level + 1'b1 : level;

    // The reload on a terminal edge already reflects a level change made on that same edge.
    speed_period_lut #(
        .SPEEDSCHED_DATAWIDTH (SPEEDSCHED_DATAWIDTH),
        .SPEEDSCHED_LEVELBITS (SPEEDSCHED_LEVELBITS),
        .SPEEDSCHED_BASE_PER  (SPEEDSCHED_BASE_PER),
        .SPEEDSCHED_STEP_PER  (SPEEDSCHED_STEP_PER),
        .SPEEDSCHED_MIN_PER   (SPEEDSCHED_MIN_PER)
    ) u_period_lut (
        .level  (levelAfter),
        .reload (reloadNext)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        stateNext   = state;
        counterNext = counter;
        levelNext   = level;
        tickCntNext = tickCnt;
        tickNext    = 1'b0;
        unique case (state)
            IDLE: begin
                counterNext = reloadNext;
                if (bus.CC_SPEEDSCHED_start_In) stateNext = RUN;
            end
            RUN: begin
                levelNext = levelAfter;
                if (terminal) begin
                    counterNext = reloadNext;
                    tickNext    = 1'b1;
                    tickCntNext = autoAdvance ? '0 : tickCnt + 1'b1;
                end else begin
                    counterNext = counter + 1'b1;
                end
                if (bus.CC_SPEEDSCHED_pause_In) stateNext = PAUSE;
            end
            PAUSE: begin
                if (bus.CC_SPEEDSCHED_pause_In) stateNext = RUN;
            end
            default: stateNext = IDLE;
        endcase
        // Stop overrides everything, including a tick due on this edge.
        if (bus.CC_SPEEDSCHED_stop_In) begin
            stateNext   = IDLE;
            counterNext = RELOAD0;
            levelNext   = '0;
            tickCntNext = '0;
            tickNext    = 1'b0;
        end
    end

    always_ff @(posedge CC_SPEEDSCHED_CLOCK_50 or negedge CC_SPEEDSCHED_RESET_InLow) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (!CC_SPEEDSCHED_RESET_InLow) state <= IDLE;
        else                            state <= stateNext;
    end

    always_ff @(posedge CC_SPEEDSCHED_CLOCK_50 or negedge CC_SPEEDSCHED_RESET_InLow) begin
        if (!CC_SPEEDSCHED_RESET_InLow) begin
            counter <= RELOAD0;
            level   <= '0;
            tickCnt <= '0;
            tick    <= 1'b0;
        end else begin
            counter <= counterNext;
            level   <= levelNext;
            tickCnt <= tickCntNext;
            tick    <= tickNext;
        end
    end

    assign bus.CC_SPEEDSCHED_tick_Out     = tick;
    assign bus.CC_SPEEDSCHED_level_OutBUS = level;
    assign bus.CC_SPEEDSCHED_running_Out  = (state == RUN);
    assign bus.CC_SPEEDSCHED_paused_Out   = (state == PAUSE);

endmodule

// File: tb/tb_speed_tick_scheduler.sv
// Bench for speed_tick_scheduler with small parameters (P = 10, 8, 6, 5 for levels 0..3):
// directed timing scenarios plus randomized commands against a cycles-remaining reference model.
module tb_speed_tick_scheduler;
    localparam int W      = 8;
    localparam int LB     = 2;
    localparam int BASE   = 10;
    localparam int STEP   = 2;
    localparam int MINP   = 5;
    localparam int TICKS  = 3;
    localparam int LEVELS = 1 << LB;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mmode_e;

    logic clk = 1'b0;
    logic rstN;
    int   nChecks = 0;
    int   nFails  = 0;

    mmode_e mMode;
    int     mLevel, mRemain, mTicks;
    logic   mTick;

    speed_tick_scheduler_if #(.LEVELBITS(LB)) bus();

    speed_tick_scheduler #(
        .SPEEDSCHED_DATAWIDTH (W),
        .SPEEDSCHED_LEVELBITS (LB),
        .SPEEDSCHED_BASE_PER  (BASE),
        .SPEEDSCHED_STEP_PER  (STEP),
        .SPEEDSCHED_MIN_PER   (MINP),
        .SPEEDSCHED_TICKS_LVL (TICKS)
    ) dut (
        .CC_SPEEDSCHED_CLOCK_50    (clk),
        .CC_SPEEDSCHED_RESET_InLow (rstN),
        .bus                       (bus)
    );

    always #5 clk = ~clk;

    function automatic int ref_period(input int lvl);
        int p;
        p = BASE - lvl * STEP;
        return (p < MINP) ? MINP : p;
    endfunction

    task automatic model_reset();
        mMode   = M_IDLE;
        mLevel  = 0;
        mTicks  = 0;
        mRemain = ref_period(0);
        mTick   = 1'b0;
    endtask

    // Model tracks cycles left until the next tick rather than a counter value.
    task automatic model_step(input logic s, input logic p, input logic st, input logic u);
        bit fire, bump;
        mTick = 1'b0;
        if (st) begin
            model_reset();
        end else begin
            case (mMode)
                M_IDLE: begin
                    mRemain = ref_period(mLevel);
                    if (s) mMode = M_RUN;
                end
                M_RUN: begin
                    mRemain = mRemain - 1;
                    fire    = (mRemain == 0);
                    bump    = u;
                    if (fire) begin
                        mTick = 1'b1;
                        if (mTicks == TICKS - 1) begin
                            mTicks = 0;
                            bump   = 1'b1;
                        end else begin
                            mTicks = mTicks + 1;
                        end
                    end
                    if (bump && mLevel < LEVELS - 1) mLevel = mLevel + 1;
                    if (fire) mRemain = ref_period(mLevel);
                    if (p) mMode = M_PAUSE;
                end
                default: begin
                    if (p) mMode = M_RUN;
                end
            endcase
        end
    endtask

    // Apply one cycle of command pulses; returns at the following falling edge.
    task automatic drive(input logic s, input logic p, input logic st, input logic u);
        bus.CC_SPEEDSCHED_start_In = s;
        bus.CC_SPEEDSCHED_pause_In = p;
        bus.CC_SPEEDSCHED_stop_In  = st;
        bus.CC_SPEEDSCHED_lvlup_In = u;
        @(posedge clk);
        model_step(s, p, st, u);
        @(negedge clk);
        bus.CC_SPEEDSCHED_start_In = 1'b0;
        bus.CC_SPEEDSCHED_pause_In = 1'b0;
        bus.CC_SPEEDSCHED_stop_In  = 1'b0;
        bus.CC_SPEEDSCHED_lvlup_In = 1'b0;
    endtask

    task automatic wait_tick(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            if (bus.CC_SPEEDSCHED_tick_Out === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic idle_ticks(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            if (bus.CC_SPEEDSCHED_tick_Out !== 1'b0) seen++;
        end
    endtask

    task automatic test_reset();
        int seen;
        rstN = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        nChecks++; if (bus.CC_SPEEDSCHED_tick_Out !== 1'b0) begin nFails++; $display("FAIL reset_tick: got %b want 0", bus.CC_SPEEDSCHED_tick_Out); end
        nChecks++; if (bus.CC_SPEEDSCHED_level_OutBUS !== 2'd0) begin nFails++; $display("FAIL reset_level: got %0d want 0", bus.CC_SPEEDSCHED_level_OutBUS); end
        nChecks++; if (bus.CC_SPEEDSCHED_running_Out !== 1'b0) begin nFails++; $display("FAIL reset_running: got %b want 0", bus.CC_SPEEDSCHED_running_Out); end
        nChecks++; if (bus.CC_SPEEDSCHED_paused_Out !== 1'b0) begin nFails++; $display("FAIL reset_paused: got %b want 0", bus.CC_SPEEDSCHED_paused_Out); end
        rstN = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        idle_ticks(5, seen);
        nChecks++; if (seen !== 0) begin nFails++; $display("FAIL idle_no_tick: got %0d ticks want 0", seen); end
        nChecks++; if (bus.CC_SPEEDSCHED_running_Out !== 1'b0 || bus.CC_SPEEDSCHED_level_OutBUS !== 2'd0) begin
            nFails++; $display("FAIL idle_ignores_pause_lvlup: running %b level %0d want 0/0", bus.CC_SPEEDSCHED_running_Out, bus.CC_SPEEDSCHED_level_OutBUS);
        end
    endtask

    task automatic test_run_period();
        int cyc;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        nChecks++; if (bus.CC_SPEEDSCHED_running_Out !== 1'b1) begin nFails++; $display("FAIL start_running: got %b want 1", bus.CC_SPEEDSCHED_running_Out); end
        wait_tick(30, cyc);
        nChecks++; if (cyc !== 10) begin nFails++; $display("FAIL first_tick_delay: got %0d want 10", cyc); end
        nChecks++; if (bus.CC_SPEEDSCHED_level_OutBUS !== 2'd0) begin nFails++; $display("FAIL first_tick_level: got %0d want 0", bus.CC_SPEEDSCHED_level_OutBUS); end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        nChecks++; if (bus.CC_SPEEDSCHED_tick_Out !== 1'b0) begin nFails++; $display("FAIL tick_one_cycle: got %b want 0", bus.CC_SPEEDSCHED_tick_Out); end
        wait_tick(30, cyc);
        nChecks++; if (cyc !== 9) begin nFails++; $display("FAIL second_tick_delay: got %0d want 9", cyc); end
    endtask

    task automatic test_level_auto();
        int cyc;
        int want [4] = '{8, 8, 8, 6};
        wait_tick(30, cyc);
        nChecks++; if (cyc !== 10) begin nFails++; $display("FAIL third_tick_delay: got %0d want 10", cyc); end
        nChecks++; if (bus.CC_SPEEDSCHED_level_OutBUS !== 2'd1) begin nFails++; $display("FAIL auto_level1: got %0d want 1", bus.CC_SPEEDSCHED_level_OutBUS); end
        for (int k = 0; k < 4; k++) begin
            wait_tick(30, cyc);
            nChecks++; if (cyc !== want[k]) begin nFails++; $display("FAIL auto_interval_%0d: got %0d want %0d", k, cyc, want[k]); end
        end
        nChecks++; if (bus.CC_SPEEDSCHED_level_OutBUS !== 2'd2) begin nFails++; $display("FAIL auto_level2: got %0d want 2", bus.CC_SPEEDSCHED_level_OutBUS); end
    endtask

    task automatic test_pause();
        int cyc, seen;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        nChecks++; if (bus.CC_SPEEDSCHED_paused_Out !== 1'b1 || bus.CC_SPEEDSCHED_running_Out !== 1'b0) begin
            nFails++; $display("FAIL pause_enter: paused %b running %b want 1/0", bus.CC_SPEEDSCHED_paused_Out, bus.CC_SPEEDSCHED_running_Out);
        end
        idle_ticks(20, seen);
        nChecks++; if (seen !== 0) begin nFails++; $display("FAIL pause_no_tick: got %0d ticks want 0", seen); end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        nChecks++; if (bus.CC_SPEEDSCHED_running_Out !== 1'b1) begin nFails++; $display("FAIL pause_resume: got %b want 1", bus.CC_SPEEDSCHED_running_Out); end
        wait_tick(30, cyc);
        nChecks++; if (cyc !== 6) begin nFails++; $display("FAIL resume_tick_delay: got %0d want 6", cyc); end
        repeat (9) drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        nChecks++; if (bus.CC_SPEEDSCHED_tick_Out !== 1'b1 || bus.CC_SPEEDSCHED_paused_Out !== 1'b1) begin
            nFails++; $display("FAIL pause_on_terminal: tick %b paused %b want 1/1", bus.CC_SPEEDSCHED_tick_Out, bus.CC_SPEEDSCHED_paused_Out);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        wait_tick(30, cyc);
        nChecks++; if (cyc !== 10) begin nFails++; $display("FAIL reload_then_pause_delay: got %0d want 10", cyc); end
    endtask

    task automatic test_level_sat();
        int cyc;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b1);
        nChecks++; if (bus.CC_SPEEDSCHED_level_OutBUS !== 2'd3) begin nFails++; $display("FAIL lvlup_saturate: got %0d want 3", bus.CC_SPEEDSCHED_level_OutBUS); end
        wait_tick(30, cyc);
        nChecks++; if (cyc !== 5) begin nFails++; $display("FAIL interval_not_shortened: got %0d want 5", cyc); end
        wait_tick(30, cyc);
        nChecks++; if (cyc !== 5) begin nFails++; $display("FAIL level3_period: got %0d want 5", cyc); end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        wait_tick(30, cyc);
        wait_tick(30, cyc);
        repeat (9) drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        nChecks++; if (bus.CC_SPEEDSCHED_tick_Out !== 1'b1 || bus.CC_SPEEDSCHED_level_OutBUS !== 2'd1) begin
            nFails++; $display("FAIL dual_trigger: tick %b level %0d want 1/1", bus.CC_SPEEDSCHED_tick_Out, bus.CC_SPEEDSCHED_level_OutBUS);
        end
        wait_tick(30, cyc);
        nChecks++; if (cyc !== 8) begin nFails++; $display("FAIL dual_trigger_period: got %0d want 8", cyc); end
    endtask

    task automatic test_stop_start();
        int cyc, seen;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        nChecks++; if (bus.CC_SPEEDSCHED_running_Out !== 1'b0 || bus.CC_SPEEDSCHED_level_OutBUS !== 2'd0 || bus.CC_SPEEDSCHED_paused_Out !== 1'b0) begin
            nFails++; $display("FAIL stop_beats_start: running %b level %0d paused %b want 0/0/0", bus.CC_SPEEDSCHED_running_Out, bus.CC_SPEEDSCHED_level_OutBUS, bus.CC_SPEEDSCHED_paused_Out);
        end
        idle_ticks(15, seen);
        nChecks++; if (seen !== 0) begin nFails++; $display("FAIL stop_no_tick: got %0d ticks want 0", seen); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (9) drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        nChecks++; if (bus.CC_SPEEDSCHED_tick_Out !== 1'b0) begin nFails++; $display("FAIL stop_on_terminal: tick %b want 0", bus.CC_SPEEDSCHED_tick_Out); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        wait_tick(30, cyc);
        nChecks++; if (cyc !== 10) begin nFails++; $display("FAIL restart_period: got %0d want 10", cyc); end
    endtask

    task automatic test_async_reset();
        int cyc, seen;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        wait_tick(30, cyc);
        nChecks++; if (cyc !== 9 || bus.CC_SPEEDSCHED_level_OutBUS !== 2'd1) begin
            nFails++; $display("FAIL pre_reset_tick: delay %0d level %0d want 9/1", cyc, bus.CC_SPEEDSCHED_level_OutBUS);
        end
        #1 rstN = 1'b0;
        model_reset();
        #1;
        nChecks++; if (bus.CC_SPEEDSCHED_tick_Out !== 1'b0 || bus.CC_SPEEDSCHED_running_Out !== 1'b0 || bus.CC_SPEEDSCHED_level_OutBUS !== 2'd0) begin
            nFails++; $display("FAIL async_reset: tick %b running %b level %0d want 0/0/0", bus.CC_SPEEDSCHED_tick_Out, bus.CC_SPEEDSCHED_running_Out, bus.CC_SPEEDSCHED_level_OutBUS);
        end
        repeat (3) @(posedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        idle_ticks(12, seen);
        nChecks++; if (seen !== 0 || bus.CC_SPEEDSCHED_running_Out !== 1'b0) begin
            nFails++; $display("FAIL post_reset_idle: ticks %0d running %b want 0/0", seen, bus.CC_SPEEDSCHED_running_Out);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        wait_tick(30, cyc);
        nChecks++; if (cyc !== 10) begin nFails++; $display("FAIL post_reset_period: got %0d want 10", cyc); end
    endtask

    task automatic test_random();
        logic s, p, st, u;
        int   tickSeen = 0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2500; i++) begin
            s  = ($urandom_range(99) < 5);
            p  = !s && ($urandom_range(99) < 3);
            st = ($urandom_range(199) < 1);
            u  = ($urandom_range(99) < 3);
            drive(s, p, st, u);
            if (mTick) tickSeen++;
            nChecks++; if (bus.CC_SPEEDSCHED_tick_Out !== mTick) begin nFails++; $display("FAIL rand_tick @%0d: got %b want %b", i, bus.CC_SPEEDSCHED_tick_Out, mTick); end
            nChecks++; if (bus.CC_SPEEDSCHED_level_OutBUS !== LB'(mLevel)) begin nFails++; $display("FAIL rand_level @%0d: got %0d want %0d", i, bus.CC_SPEEDSCHED_level_OutBUS, mLevel); end
            nChecks++; if (bus.CC_SPEEDSCHED_running_Out !== (mMode == M_RUN)) begin nFails++; $display("FAIL rand_running @%0d: got %b want %b", i, bus.CC_SPEEDSCHED_running_Out, mMode == M_RUN); end
            nChecks++; if (bus.CC_SPEEDSCHED_paused_Out !== (mMode == M_PAUSE)) begin nFails++; $display("FAIL rand_paused @%0d: got %b want %b", i, bus.CC_SPEEDSCHED_paused_Out, mMode == M_PAUSE); end
        end
        nChecks++; if (tickSeen < 20) begin nFails++; $display("FAIL rand_activity: got %0d model ticks want >= 20", tickSeen); end
    endtask

    initial begin
        bus.CC_SPEEDSCHED_start_In = 1'b0;
        bus.CC_SPEEDSCHED_pause_In = 1'b0;
        bus.CC_SPEEDSCHED_stop_In  = 1'b0;
        bus.CC_SPEEDSCHED_lvlup_In = 1'b0;
        test_reset();
        test_run_period();
        test_level_auto();
        test_pause();
        test_level_sat();
        test_stop_start();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
